aes_round_sequencer: RTL and testbench
======================================

Name: aes_round_sequencer

Overview:
Control FSM that runs one 128-bit AES-128 block through the shared single-round datapath (SubBytes, ShiftRows, MixColumns, AddRoundKey) NUM_ROUNDS times. Per block it: accepts plaintext, applies key-0 whitening, fetches each round key from the key-schedule memory, pulses the datapath run, waits the fixed datapath latency and feeds the result back. It asserts dp_final on the last round so the external mux bypasses MixColumns. It sits between the host stream interface and the round datapath plus key RAM.

Parameters:
NUM_ROUNDS, 10, rounds after whitening (AES-128); legal range 1..15.
ROUND_LAT, 4, cycles from a dp_run cycle to valid dp_result; legal range 1..15.
KEY_ADDR_W, 4, key memory address width; must satisfy 2^KEY_ADDR_W > NUM_ROUNDS.

Ports:
clk  input  1  clock, rising-edge.
rst  input  1  asynchronous, active-low reset.
in_valid  input  1  plaintext valid.
in_ready  output  1  sequencer can accept a block.
in_data  input  128  plaintext; byte 0 = [127:120].
abort  input  1  synchronous cancel of the current block.
key_addr  output  KEY_ADDR_W  round-key index, registered.
key_rdata  input  128  round key; valid in the cycle after key_addr is held.
dp_run  output  1  one-cycle start pulse to the datapath.
dp_final  output  1  last round; datapath bypasses MixColumns.
dp_state  output  128  state register, drives datapath in0..in15.
dp_key  output  128  latched round key, drives datapath in16..in31.
dp_result  input  128  datapath out0..out15.
out_valid  output  1  ciphertext valid.
out_ready  input  1  consumer accepts ciphertext.
out_data  output  128  ciphertext (= dp_state in DONE).
busy  output  1  high in any state other than IDLE.
round_cnt  output  4  current round number.

Behaviour:
- Reset (rst=0, asynchronous) forces FSM=IDLE. State reg, dp_key, key_addr and round_cnt go to 0. dp_run, dp_final, out_valid and busy go to 0. in_ready goes to 1.
- Reset asserted mid-block discards the block; no out_valid is produced.
- FSM states: IDLE, KEY0, WHITEN, FETCH, LOAD, RUN, WAIT, DONE.
- IDLE: in_ready=1. On in_valid, state<=in_data, key_addr<=0, go to KEY0.
- KEY0: one cycle holding key_addr; go to WHITEN.
- WHITEN: state<=state^key_rdata, key_addr<=1, round_cnt<=1, go to FETCH.
- FETCH: key_addr=round_cnt held for one cycle; go to LOAD.
- LOAD: dp_key<=key_rdata; go to RUN.
- RUN: dp_run=1 for exactly this cycle; WAIT counter<=ROUND_LAT-1.
- WAIT: lasts ROUND_LAT cycles, with dp_state and dp_key held stable throughout. At the edge ending the last WAIT cycle, state<=dp_result.
  - If round_cnt<NUM_ROUNDS: round_cnt++, key_addr<=round_cnt+1, go to FETCH.
  - Otherwise go to DONE.
- dp_final=1 in FETCH, LOAD, RUN and WAIT only while round_cnt==NUM_ROUNDS; otherwise 0.
- DONE: out_valid=1, with out_data stable until out_valid && out_ready. On that handshake go to IDLE; in_ready rises the next cycle. No same-cycle output/input overlap.
- out_ready held low keeps DONE indefinitely. in_valid is ignored outside IDLE.
- Latency: accept edge, then KEY0 and WHITEN (2 cycles), then NUM_ROUNDS*(3+ROUND_LAT) cycles, then DONE. With defaults, out_valid first asserts in cycle 73 after the accept edge.
- round_cnt: 0 in IDLE, KEY0 and WHITEN; r during round r; NUM_ROUNDS in DONE.
- abort (sampled in any non-IDLE state) forces IDLE on the next edge, with dp_run=0 and out_valid=0 from that edge. abort in DONE drops the pending output. abort in IDLE has no effect. abort takes priority over every other transition, including the DONE handshake in the same cycle.
- round_cnt is 4 bits wide; the counter never wraps because NUM_ROUNDS<=15.

Test Plan:
1. FIPS-197 vector: key memory holds the expanded schedule of 000102030405060708090a0b0c0d0e0f; in_data=00112233445566778899aabbccddeeff; behavioural round model with ROUND_LAT=4. Required: out_data=69c4e0d86a7b0430d8cdb78070b4c55a, out_valid in cycle 73, exactly 10 dp_run pulses, dp_final high only in round 10.
2. Backpressure: out_ready=0 for 20 cycles after out_valid. Required: out_valid/out_data stable, in_ready=0, then IDLE one cycle after the handshake.
3. Back-to-back: two blocks with in_valid held high. Required: second accept in the cycle after the first handshake, both ciphertexts correct.
4. Abort during WAIT of round 5. Required: dp_run=0 and busy=0 next cycle, no out_valid, following block correct.
5. Reset pulse (rst=0) in round 3. Required: all outputs at reset values immediately, and the next block after release is correct.
6. Parameter sweep ROUND_LAT=1 and NUM_ROUNDS=1. Required: key_addr sequence 0,1; one dp_run with dp_final=1; out_valid in cycle 2+1*(3+ROUND_LAT)+1.

Source files
------------

// File: rtl/aes_round_sequencer.sv
// ---------------------------------------------------------------------------
// aes_round_sequencer
//
// Control FSM that walks one 128-bit AES block through a shared single-round
// datapath. Per block: capture plaintext, whiten it with round key 0, then for
// each round fetch the key from the key RAM, pulse the datapath and wait its
// fixed latency before feeding the result back into the state register.
//
// Ports
//   clk, rst          rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready plaintext handshake, in_data byte 0 = [127:120]
//   abort             synchronous cancel of the block in flight
//   key_addr          registered round-key index into the key RAM
//   key_rdata         round key, valid the cycle after key_addr is held
//   dp_run            one-cycle start pulse to the round datapath
//   dp_final          last round, datapath bypasses MixColumns
//   dp_state, dp_key  datapath operands (state register, latched round key)
//   dp_result         datapath output, valid ROUND_LAT cycles after dp_run
//   out_valid/ready   ciphertext handshake, out_data = state register
//   busy              FSM not idle
//   round_cnt         current round number
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module aes_round_sequencer #(
    parameter int NUM_ROUNDS = 10, // rounds after whitening, 1..15
    parameter int ROUND_LAT  = 4,  // dp_run to valid dp_result, 1..15
    parameter int KEY_ADDR_W = 4   // 2**KEY_ADDR_W must exceed NUM_ROUNDS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [127:0]          in_data,
    input  logic                  abort,
    output logic [KEY_ADDR_W-1:0] key_addr,
    input  logic [127:0]          key_rdata,
    output logic                  dp_run,
    output logic                  dp_final,
    output logic [127:0]          dp_state,
    output logic [127:0]          dp_key,
    input  logic [127:0]          dp_result,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [127:0]          out_data,
    output logic                  busy,
    output logic [3:0]            round_cnt
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_KEY0   = 3'd1;
    localparam logic [2:0] S_WHITEN = 3'd2;
    localparam logic [2:0] S_FETCH  = 3'd3;
    localparam logic [2:0] S_LOAD   = 3'd4;
    localparam logic [2:0] S_RUN    = 3'd5;
    localparam logic [2:0] S_WAIT   = 3'd6;
    localparam logic [2:0] S_DONE   = 3'd7;

    localparam logic [3:0]            LAST_ROUND = 4'(NUM_ROUNDS);
    localparam logic [3:0]            WAIT_INIT  = 4'(ROUND_LAT - 1);
    localparam logic [KEY_ADDR_W-1:0] KEY_FIRST  = KEY_ADDR_W'(1);

    logic [2:0]            fsm_q, fsm_d;
    logic [127:0]          state_q, state_d;
    logic [127:0]          key_q, key_d;
    logic [KEY_ADDR_W-1:0] key_addr_q, key_addr_d;
    logic [3:0]            round_q, round_d;
    logic [3:0]            wait_q, wait_d;
    logic [3:0]            next_round;
    logic                  in_round;

    // round_q never exceeds NUM_ROUNDS <= 15, so the increment cannot wrap.
    assign next_round = round_q + 4'd1;

    // The datapath operands are live from FETCH through the end of WAIT.
    assign in_round = (fsm_q == S_FETCH) || (fsm_q == S_LOAD) ||
                      (fsm_q == S_RUN)   || (fsm_q == S_WAIT);

    assign in_ready  = (fsm_q == S_IDLE);
    assign busy      = (fsm_q != S_IDLE);
    assign dp_run    = (fsm_q == S_RUN);
    assign dp_final  = in_round && (round_q == LAST_ROUND);
    assign out_valid = (fsm_q == S_DONE);
    assign dp_state  = state_q;
    assign dp_key    = key_q;
    assign out_data  = state_q;
    assign key_addr  = key_addr_q;
    assign round_cnt = round_q;

    always_comb begin
        // NOTE: every _d starts from its _q, so paths that leave a register
        // untouched hold it instead of inferring a latch.
        fsm_d      = fsm_q;
        state_d    = state_q;
        key_d      = key_q;
        key_addr_d = key_addr_q;
        round_d    = round_q;
        wait_d     = wait_q;

        case (fsm_q)
            S_IDLE: begin
                if (in_valid) begin
                    state_d    = in_data;
                    key_addr_d = '0;
                    round_d    = '0;
                    fsm_d      = S_KEY0;
                end
            end
            // Key RAM is read synchronously: key 0 appears one cycle later.
            S_KEY0: fsm_d = S_WHITEN;
            S_WHITEN: begin
                state_d    = state_q ^ key_rdata;
                key_addr_d = KEY_FIRST;
                round_d    = 4'd1;
                fsm_d      = S_FETCH;
            end
            S_FETCH: fsm_d = S_LOAD;
            S_LOAD: begin
                key_d = key_rdata;
                fsm_d = S_RUN;
            end
            S_RUN: begin
                wait_d = WAIT_INIT;
                fsm_d  = S_WAIT;
            end
            S_WAIT: begin
                // wait_q counts ROUND_LAT-1 down to 0: ROUND_LAT cycles total,
                // the last of which is the one where dp_result is valid.
                if (wait_q == 4'd0) begin
                    state_d = dp_result;
                    if (round_q < LAST_ROUND) begin
                        round_d    = next_round;
                        key_addr_d = KEY_ADDR_W'(next_round);
                        fsm_d      = S_FETCH;
                    end else begin
                        fsm_d = S_DONE;
                    end
                end else begin
                    wait_d = wait_q - 4'd1;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    round_d = '0;
                    fsm_d   = S_IDLE;
                end
            end
            default: fsm_d = S_IDLE;
        endcase

        // Abort outranks everything, including the DONE handshake.
        if (abort && (fsm_q != S_IDLE)) begin
            fsm_d      = S_IDLE;
            round_d    = '0;
            key_addr_d = '0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values computed above.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fsm_q      <= S_IDLE;
            state_q    <= '0;
            key_q      <= '0;
            key_addr_q <= '0;
            round_q    <= '0;
            wait_q     <= '0;
        end else begin
            fsm_q      <= fsm_d;
            state_q    <= state_d;
            key_q      <= key_d;
            key_addr_q <= key_addr_d;
            round_q    <= round_d;
            wait_q     <= wait_d;
        end
    end

endmodule

// File: tb/tb_aes_round_sequencer.sv
// ---------------------------------------------------------------------------
// tb_aes_round_sequencer
//
// Two sequencers share clock and reset: u_dut with default parameters and
// u_dut_s with NUM_ROUNDS=1, ROUND_LAT=1. Each has a synchronous key RAM
// model and a behavioural round datapath whose result is only valid in the
// ROUND_LAT-th cycle after dp_run. Expected ciphertexts come from a plain
// AES model (S-box from GF(2^8) inversion, key expansion, round function).
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_aes_round_sequencer;

    localparam int NA = 10;
    localparam int LA = 4;
    localparam int NS = 1;
    localparam int LS = 1;

    localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] POISON   = 128'hdeadbeef_0badf00d_deadbeef_0badf00d;
    // {dp_run, dp_final, busy, in_ready, out_valid, round_cnt, key_addr}
    localparam logic [12:0]  CTL_RESET = 13'b0_0_0_1_0_0000_0000;
    // {dp_run, dp_final, busy, in_ready, out_valid, round_cnt}
    localparam logic [8:0]   CTL_IDLE  = 9'b0_0_0_1_0_0000;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid, abort, out_ready, sel;
    logic [127:0] in_data;

    int vectors = 0;
    int miscompares = 0;

    logic [127:0] rk [16];

    always #5 clk = ~clk;

    // ---------------- AES reference ----------------
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, aa;
        p = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] t, inv;
        t = x;
        inv = 8'h01;
        for (int i = 0; i < 7; i++) begin
            t = gmul(t, t);
            inv = gmul(inv, t);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
               {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] k,
                                               input logic fin);
        logic [7:0]   b [16];
        logic [7:0]   t [16];
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] o;
        for (int i = 0; i < 16; i++) b[i] = sbox(s[127-8*i -: 8]);
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) t[r+4*c] = b[r + 4*((c+r)%4)];
        if (!fin) begin
            for (int c = 0; c < 4; c++) begin
                a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
                t[4*c]   = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
                t[4*c+1] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
                t[4*c+2] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
                t[4*c+3] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
            end
        end
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = t[i];
        return o ^ k;
    endfunction

    task automatic expand_key(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])} ^ {rc, 24'h0};
                rc = xtime(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        for (int r = 11; r < 16; r++) rk[r] = {$urandom(), $urandom(), $urandom(), $urandom()};
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Expected control outputs in cycle c after the accept edge, derived from
    // the block timeline: KEY0, WHITEN, then n rounds of FETCH, LOAD, RUN and
    // l WAIT cycles, then DONE.
    function automatic logic [12:0] exp_ctl(input int c, input int n, input int l);
        int total, r, p;
        total = 2 + n * (3 + l);
        if (c <= 2) return 13'b0_0_1_0_0_0000_0000;
        if (c > total) return {1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'(n), 4'(n)};
        r = (c - 3) / (3 + l) + 1;
        p = (c - 3) % (3 + l);
        return {p == 2, r == n, 1'b1, 1'b0, 1'b0, 4'(r), 4'(r)};
    endfunction

    // ---------------- DUTs and their key RAM / datapath models ----------------
    logic         a_in_ready, a_dp_run, a_dp_final, a_out_valid, a_busy;
    logic [3:0]   a_key_addr, a_round_cnt;
    logic [127:0] a_key_rdata, a_dp_state, a_dp_key, a_dp_result, a_out_data;
    logic         s_in_ready, s_dp_run, s_dp_final, s_out_valid, s_busy;
    logic [3:0]   s_key_addr, s_round_cnt;
    logic [127:0] s_key_rdata, s_dp_state, s_dp_key, s_dp_result, s_out_data;

    aes_round_sequencer #(.NUM_ROUNDS(NA), .ROUND_LAT(LA), .KEY_ADDR_W(4)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid && !sel), .in_ready(a_in_ready),
        .in_data(in_data), .abort(abort && !sel), .key_addr(a_key_addr),
        .key_rdata(a_key_rdata), .dp_run(a_dp_run), .dp_final(a_dp_final),
        .dp_state(a_dp_state), .dp_key(a_dp_key), .dp_result(a_dp_result),
        .out_valid(a_out_valid), .out_ready(out_ready && !sel), .out_data(a_out_data),
        .busy(a_busy), .round_cnt(a_round_cnt)
    );

    aes_round_sequencer #(.NUM_ROUNDS(NS), .ROUND_LAT(LS), .KEY_ADDR_W(4)) u_dut_s (
        .clk(clk), .rst(rst), .in_valid(in_valid && sel), .in_ready(s_in_ready),
        .in_data(in_data), .abort(abort && sel), .key_addr(s_key_addr),
        .key_rdata(s_key_rdata), .dp_run(s_dp_run), .dp_final(s_dp_final),
        .dp_state(s_dp_state), .dp_key(s_dp_key), .dp_result(s_dp_result),
        .out_valid(s_out_valid), .out_ready(out_ready && sel), .out_data(s_out_data),
        .busy(s_busy), .round_cnt(s_round_cnt)
    );

    always @(posedge clk) a_key_rdata <= rk[a_key_addr];
    always @(posedge clk) s_key_rdata <= rk[s_key_addr];

    int           a_cnt = 0;
    int           s_cnt = 0;
    logic [127:0] a_pend = '0;
    logic [127:0] s_pend = '0;

    always @(posedge clk) begin
        if (a_dp_run) begin
            a_pend <= aes_round(a_dp_state, a_dp_key, a_dp_final);
            a_cnt  <= LA;
        end else if (a_cnt != 0) begin
            a_cnt <= a_cnt - 1;
        end
    end

    always @(posedge clk) begin
        if (s_dp_run) begin
            s_pend <= aes_round(s_dp_state, s_dp_key, s_dp_final);
            s_cnt  <= LS;
        end else if (s_cnt != 0) begin
            s_cnt <= s_cnt - 1;
        end
    end

    assign a_dp_result = (a_cnt == 1) ? a_pend : POISON;
    assign s_dp_result = (s_cnt == 1) ? s_pend : POISON;

    // View of whichever instance is under test.
    logic         v_in_ready, v_out_valid, v_busy;
    logic [127:0] v_dp_state, v_dp_key, v_out_data;
    logic [12:0]  v_ctl;

    always_comb begin
        if (sel) begin
            v_in_ready = s_in_ready; v_out_valid = s_out_valid; v_busy = s_busy;
            v_dp_state = s_dp_state; v_dp_key = s_dp_key; v_out_data = s_out_data;
            v_ctl = {s_dp_run, s_dp_final, s_busy, s_in_ready, s_out_valid, s_round_cnt, s_key_addr};
        end else begin
            v_in_ready = a_in_ready; v_out_valid = a_out_valid; v_busy = a_busy;
            v_dp_state = a_dp_state; v_dp_key = a_dp_key; v_out_data = a_out_data;
            v_ctl = {a_dp_run, a_dp_final, a_busy, a_in_ready, a_out_valid, a_round_cnt, a_key_addr};
        end
    end

    // ---------------- helpers ----------------
    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full block: accept, per-cycle timeline checks, optional stall in
    // DONE, then handshake (or abort with out_ready high when drop is set).
    task automatic run_block(input logic [127:0] pt, input int stall, input bit keep,
                             input logic [127:0] next_pt, input bit drop,
                             output int waited, output logic [127:0] ct);
        int n_r, lat, total, n, r, p;
        logic [127:0] rin;
        n_r = sel ? NS : NA;
        lat = sel ? LS : LA;
        total = 2 + n_r * (3 + lat);
        in_data = pt;
        in_valid = 1'b1;
        out_ready = 1'b0;
        n = 0;
        while (v_in_ready !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        waited = n;
        check("accept_ready", 128'(v_in_ready), 128'(1));
        tick();
        abort = 1'b0;
        if (keep) in_data = next_pt;
        else in_valid = 1'b0;
        rin = pt ^ rk[0];
        for (int c = 1; c <= total + 1; c++) begin
            check("ctl", 128'(v_ctl), 128'(exp_ctl(c, n_r, lat)));
            if (c >= 3 && c <= total) begin
                r = (c - 3) / (3 + lat) + 1;
                p = (c - 3) % (3 + lat);
                if (p >= 2) begin
                    check("round_state", v_dp_state, rin);
                    check("round_key", v_dp_key, rk[r]);
                end
                if (p == 2 + lat) rin = aes_round(rin, rk[r], r == n_r);
            end
            if (c <= total) tick();
        end
        check("out_data", v_out_data, rin);
        ct = v_out_data;
        for (int k = 0; k < stall; k++) begin
            tick();
            check("stall_ctl", 128'(v_ctl), 128'(exp_ctl(total + 1, n_r, lat)));
            check("stall_data", v_out_data, rin);
        end
        if (drop) abort = 1'b1;
        out_ready = 1'b1;
        tick();
        abort = 1'b0;
        out_ready = 1'b0;
        check("post_idle", 128'(v_ctl[12:4]), 128'(CTL_IDLE));
    endtask

    // Start a block on u_dut and interrupt it with abort (WAIT of the given
    // round) or a reset pulse (LOAD of the given round).
    task automatic run_interrupt(input logic [127:0] pt, input int round, input bit use_reset);
        int target, n;
        logic seen;
        in_data = pt;
        in_valid = 1'b1;
        n = 0;
        while (v_in_ready !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        check("irq_accept_ready", 128'(v_in_ready), 128'(1));
        tick();
        in_valid = 1'b0;
        target = 3 + (3 + LA) * (round - 1) + (use_reset ? 1 : 4);
        for (int c = 1; c < target; c++) tick();
        check("irq_point", 128'(v_ctl), 128'(exp_ctl(target, NA, LA)));
        if (use_reset) begin
            rst = 1'b0;
            #1;
            check("rst_ctl", 128'(v_ctl), 128'(CTL_RESET));
            check("rst_state", v_dp_state, 128'h0);
            check("rst_key", v_dp_key, 128'h0);
            tick();
            tick();
            rst = 1'b1;
        end else begin
            abort = 1'b1;
            tick();
            abort = 1'b0;
            check("abort_ctl", 128'(v_ctl[12:4]), 128'(CTL_IDLE));
        end
        seen = 1'b0;
        for (int k = 0; k < 100; k++) begin
            tick();
            seen = seen | v_out_valid;
        end
        check("no_out_valid", 128'(seen), 128'(0));
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int           waited;
        logic [127:0] ct, p1, p2;

        rst = 1'b0;
        in_valid = 1'b0;
        abort = 1'b0;
        out_ready = 1'b0;
        in_data = '0;
        sel = 1'b0;
        expand_key(FIPS_KEY);

        #12;
        check("reset_ctl", 128'(v_ctl), 128'(CTL_RESET));
        check("reset_state", v_dp_state, 128'h0);
        check("reset_key", v_dp_key, 128'h0);
        tick();
        rst = 1'b1;
        tick();

        // FIPS-197 known answer
        run_block(FIPS_PT, 0, 1'b0, '0, 1'b0, waited, ct);
        check("fips_ct", ct, FIPS_CT);

        // Backpressure
        run_block(rnd128(), 20, 1'b0, '0, 1'b0, waited, ct);

        // Back-to-back with in_valid held high
        p1 = rnd128();
        p2 = rnd128();
        run_block(p1, 0, 1'b1, p2, 1'b0, waited, ct);
        run_block(p2, 0, 1'b0, '0, 1'b0, waited, ct);
        check("b2b_accept_wait", 128'(waited), 128'(0));

        // Abort in WAIT of round 5, then a clean block
        run_interrupt(rnd128(), 5, 1'b0);
        run_block(rnd128(), 1, 1'b0, '0, 1'b0, waited, ct);

        // Reset pulse in round 3, then a clean block
        run_interrupt(rnd128(), 3, 1'b1);
        run_block(rnd128(), 0, 1'b0, '0, 1'b0, waited, ct);

        // Abort in DONE together with out_ready drops the output
        run_block(rnd128(), 3, 1'b0, '0, 1'b1, waited, ct);

        // Abort while idle does not block acceptance
        abort = 1'b1;
        run_block(rnd128(), 0, 1'b0, '0, 1'b0, waited, ct);

        // Random keys and plaintexts
        for (int i = 0; i < 3; i++) begin
            expand_key(rnd128());
            run_block(rnd128(), int'($urandom_range(0, 5)), 1'b0, '0, 1'b0, waited, ct);
        end

        // Minimal configuration: NUM_ROUNDS=1, ROUND_LAT=1
        sel = 1'b1;
        expand_key(FIPS_KEY);
        run_block(FIPS_PT, 0, 1'b0, '0, 1'b0, waited, ct);
        expand_key(rnd128());
        run_block(rnd128(), 2, 1'b0, '0, 1'b0, waited, ct);
        sel = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
